// File: rtl/gpio_regfile_p.sv
// GPIO/ID register bank: 32-bit word bus, LO/HI split registers, set/clear aliases,
// synchronised inputs and edge interrupts with W1C status. Optional macro: GPIO_BOTH_EDGE_EN (INT_ANY).
module gpio_regfile_p #(
  parameter int unsigned PIN_W        = 64,
  parameter int unsigned ADDR_W       = 11,
  parameter logic [31:0] CHIP_NAME    = 32'h5256_4943,
  parameter logic [31:0] CHIP_VERSION = 32'h0000_0002
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              r_wn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  input  logic [PIN_W-1:0]  pin_in,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  output logic              irq
);

  localparam int unsigned PAIR_W = ADDR_W - 1;
  localparam logic [PAIR_W-1:0] P_ID  = PAIR_W'(0);
  localparam logic [PAIR_W-1:0] P_OUT = PAIR_W'(1);
  localparam logic [PAIR_W-1:0] P_OE  = PAIR_W'(2);
  localparam logic [PAIR_W-1:0] P_PIN = PAIR_W'(3);
  localparam logic [PAIR_W-1:0] P_EN  = PAIR_W'(4);
  localparam logic [PAIR_W-1:0] P_POL = PAIR_W'(5);
  localparam logic [PAIR_W-1:0] P_STS = PAIR_W'(6);
  localparam logic [PAIR_W-1:0] P_SET = PAIR_W'(7);
  localparam logic [PAIR_W-1:0] P_CLR = PAIR_W'(8);
`ifdef GPIO_BOTH_EDGE_EN
  localparam logic [PAIR_W-1:0] P_ANY = PAIR_W'(9);
`endif

  logic [PIN_W-1:0] out_q, oe_q, en_q, pol_q, sts_q, s1_q, s2_q, prev_q;
  logic [PIN_W-1:0] out_nxt, oe_nxt, en_nxt, pol_nxt, sts_nxt, w1c_c;
  logic [PIN_W-1:0] rise_c, fall_c, edge_c, match_c;
  logic [PAIR_W-1:0] pair;
  logic              hi;
  logic [63:0]       wpos, wmask, sel64;
  logic [31:0]       rdata_nxt;
`ifdef GPIO_BOTH_EDGE_EN
  logic [PIN_W-1:0] any_q, any_nxt;
`endif

  assign pair  = addr[ADDR_W-1:1];
  assign hi    = addr[0];
  assign wpos  = hi ? {wdata, 32'h0} : {32'h0, wdata};
  assign wmask = hi ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};

  // Replace one 32-bit half of a register; bits at or above PIN_W fall away.
  function automatic logic [PIN_W-1:0] merge(input logic [PIN_W-1:0] cur,
                                             input logic [63:0] pos,
                                             input logic [63:0] msk);
    return PIN_W'((64'(cur) & ~msk) | pos);
  endfunction

  // Edge events come from the synchronised sample and its one-cycle-old copy.
  always_comb begin
    rise_c = s2_q & ~prev_q;
    fall_c = ~s2_q & prev_q;
    edge_c = (pol_q & rise_c) | (~pol_q & fall_c);
`ifdef GPIO_BOTH_EDGE_EN
    edge_c = edge_c | (any_q & (rise_c | fall_c));
`endif
    match_c = en_q & edge_c;
  end

  // Write decode and next-state.
  always_comb begin
    out_nxt = out_q;
    oe_nxt  = oe_q;
    en_nxt  = en_q;
    pol_nxt = pol_q;
    w1c_c   = '0;
`ifdef GPIO_BOTH_EDGE_EN
    any_nxt = any_q;
`endif
    if (req && !r_wn) begin
      case (pair)
        P_OUT:   out_nxt = merge(out_q, wpos, wmask);
        P_OE:    oe_nxt  = merge(oe_q, wpos, wmask);
        P_EN:    en_nxt  = merge(en_q, wpos, wmask);
        P_POL:   pol_nxt = merge(pol_q, wpos, wmask);
        P_STS:   w1c_c   = PIN_W'(wpos);
        P_SET:   out_nxt = out_q | PIN_W'(wpos);
        P_CLR:   out_nxt = out_q & ~PIN_W'(wpos);
`ifdef GPIO_BOTH_EDGE_EN
        P_ANY:   any_nxt = merge(any_q, wpos, wmask);
`endif
        default: ;
      endcase
    end
    // A new event on a bit beats a simultaneous W1C of that bit.
    sts_nxt = (sts_q & ~w1c_c) | match_c;
  end

  // Read mux; rdata is zero whenever no read is acked.
  always_comb begin
    sel64     = '0;
    rdata_nxt = '0;
    if (req && r_wn) begin
      case (pair)
        P_ID:           sel64 = {CHIP_VERSION, CHIP_NAME};
        P_OUT, P_SET,
        P_CLR:          sel64 = 64'(out_q);
        P_OE:           sel64 = 64'(oe_q);
        P_PIN:          sel64 = 64'(s2_q);
        P_EN:           sel64 = 64'(en_q);
        P_POL:          sel64 = 64'(pol_q);
        P_STS:          sel64 = 64'(sts_q);
`ifdef GPIO_BOTH_EDGE_EN
        P_ANY:          sel64 = 64'(any_q);
`endif
        default:        sel64 = '0;
      endcase
      rdata_nxt = hi ? sel64[63:32] : sel64[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      pol_q  <= '0;
      sts_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      ack    <= 1'b0;
      rdata  <= '0;
      irq    <= 1'b0;
`ifdef GPIO_BOTH_EDGE_EN
      any_q  <= '0;
`endif
    end else begin
      out_q  <= out_nxt;
      oe_q   <= oe_nxt;
      en_q   <= en_nxt;
      pol_q  <= pol_nxt;
      sts_q  <= sts_nxt;
      s1_q   <= pin_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      ack    <= req;
      rdata  <= rdata_nxt;
      irq    <= |sts_nxt;
`ifdef GPIO_BOTH_EDGE_EN
      any_q  <= any_nxt;
`endif
    end
  end

  assign pin_out = out_q;
  assign pin_oe  = oe_q;

endmodule

// File: tb/tb_gpio_regfile_p.sv
// Self-checking bench for gpio_regfile_p: directed scenarios plus randomized traffic
// checked against a register-map reference model; a second 8-pin instance covers width masking.
module tb_gpio_regfile_p;

  localparam logic [31:0] EXP_NAME = 32'h5256_4943;
  localparam logic [31:0] EXP_VER  = 32'h0000_0002;

  logic        clk = 1'b0;
  logic        rst_n, req, r_wn;
  logic [10:0] addr;
  logic [31:0] wdata, rdata, rdata8;
  logic        ack, ack8, irq, irq8;
  logic [63:0] pin_in, pin_out, pin_oe;
  logic [7:0]  pin_in8, pin_out8, pin_oe8;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gpio_regfile_p u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .r_wn(r_wn), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  gpio_regfile_p #(.PIN_W(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req), .r_wn(r_wn), .addr(addr), .wdata(wdata),
    .rdata(rdata8), .ack(ack8), .pin_in(pin_in8), .pin_out(pin_out8), .pin_oe(pin_oe8), .irq(irq8)
  );

  // Reference model of the 64-pin register map.
  logic [63:0] m_out, m_oe, m_en, m_pol, m_sts, m_any;
  logic [63:0] hist [3];   // pad samples: [0] newest, [1] visible as PINSTATE, [2] one older
  logic        m_ack, m_irq;
  logic [31:0] m_rdata;

  function automatic logic [31:0] m_read(input logic [10:0] a);
    case (a)
      11'h000: return EXP_NAME;
      11'h001: return EXP_VER;
      11'h002, 11'h00E, 11'h010: return m_out[31:0];
      11'h003, 11'h00F, 11'h011: return m_out[63:32];
      11'h004: return m_oe[31:0];
      11'h005: return m_oe[63:32];
      11'h006: return hist[1][31:0];
      11'h007: return hist[1][63:32];
      11'h008: return m_en[31:0];
      11'h009: return m_en[63:32];
      11'h00A: return m_pol[31:0];
      11'h00B: return m_pol[63:32];
      11'h00C: return m_sts[31:0];
      11'h00D: return m_sts[63:32];
`ifdef GPIO_BOTH_EDGE_EN
      11'h012: return m_any[31:0];
      11'h013: return m_any[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [63:0] put_word(input logic [63:0] r, input logic h, input logic [31:0] d);
    return h ? {d, r[31:0]} : {r[63:32], d};
  endfunction

  always @(posedge clk) begin
    logic [63:0] rise, fall, ev, w1c, pos;
    if (!rst_n) begin
      m_out = '0; m_oe = '0; m_en = '0; m_pol = '0; m_sts = '0; m_any = '0;
      hist[0] = '0; hist[1] = '0; hist[2] = '0;
      m_ack = 1'b0; m_rdata = '0; m_irq = 1'b0;
    end else begin
      rise = hist[1] & ~hist[2];
      fall = ~hist[1] & hist[2];
      ev   = m_en & ((m_pol & rise) | (~m_pol & fall) | (m_any & (rise | fall)));
      w1c  = '0;
      pos  = addr[0] ? {wdata, 32'h0} : {32'h0, wdata};
      m_ack   = req;
      m_rdata = (req && r_wn) ? m_read(addr) : 32'h0;
      if (req && !r_wn) begin
        case (addr)
          11'h002, 11'h003: m_out = put_word(m_out, addr[0], wdata);
          11'h004, 11'h005: m_oe  = put_word(m_oe, addr[0], wdata);
          11'h008, 11'h009: m_en  = put_word(m_en, addr[0], wdata);
          11'h00A, 11'h00B: m_pol = put_word(m_pol, addr[0], wdata);
          11'h00C, 11'h00D: w1c   = pos;
          11'h00E, 11'h00F: m_out = m_out | pos;
          11'h010, 11'h011: m_out = m_out & ~pos;
`ifdef GPIO_BOTH_EDGE_EN
          11'h012, 11'h013: m_any = put_word(m_any, addr[0], wdata);
`endif
          default: ;
        endcase
      end
      m_sts = (m_sts & ~w1c) | ev;
      m_irq = (m_sts != 64'h0);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = pin_in;
    end
  end

  // One bus access starting at a negedge; returns what is visible at the next negedge.
  task automatic access(input logic rw, input logic [10:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic ak);
    req = 1'b1; r_wn = rw; addr = a; wdata = d;
    @(negedge clk);
    rd = rdata; ak = ack;
    req = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic ak;
    rst_n = 1'b0; req = 1'b0; r_wn = 1'b1; addr = '0; wdata = '0; pin_in = '0; pin_in8 = '0;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({ack, rdata, pin_out, pin_oe, irq} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got ack=%b rdata=%h out=%h oe=%h irq=%b want all 0",
                         ack, rdata, pin_out, pin_oe, irq);
    end
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 11'h000, '0, rd, ak);
    n_assert++;
    if (ak !== 1'b1 || rd !== EXP_NAME) begin
      n_fail++; $display("FAIL reset_cname: got ack=%b rdata=%h want 1 %h", ak, rd, EXP_NAME);
    end
    access(1'b1, 11'h001, '0, rd, ak);
    n_assert++;
    if (ak !== 1'b1 || rd !== EXP_VER) begin
      n_fail++; $display("FAIL reset_cversion: got ack=%b rdata=%h want 1 %h", ak, rd, EXP_VER);
    end
  endtask

  task automatic test_output();
    logic [31:0] rd; logic ak;
    access(1'b0, 11'h002, 32'hA5A5_0000, rd, ak);
    n_assert++;
    if (pin_out[31:0] !== 32'hA5A5_0000) begin
      n_fail++; $display("FAIL out_write: got %h want a5a50000", pin_out[31:0]);
    end
    access(1'b0, 11'h00E, 32'h0000_00FF, rd, ak);
    n_assert++;
    if (pin_out[31:0] !== 32'hA5A5_00FF) begin
      n_fail++; $display("FAIL out_set: got %h want a5a500ff", pin_out[31:0]);
    end
    access(1'b0, 11'h010, 32'h0000_000F, rd, ak);
    n_assert++;
    if (pin_out[31:0] !== 32'hA5A5_00F0) begin
      n_fail++; $display("FAIL out_clr: got %h want a5a500f0", pin_out[31:0]);
    end
    access(1'b1, 11'h010, '0, rd, ak);
    n_assert++;
    if (rd !== 32'hA5A5_00F0) begin
      n_fail++; $display("FAIL out_clr_read: got %h want a5a500f0", rd);
    end
  endtask

  task automatic test_pin_w8();
    logic [31:0] rd; logic ak;
    access(1'b0, 11'h003, 32'hFFFF_FFFF, rd, ak);
    access(1'b0, 11'h004, 32'hFFFF_FFFF, rd, ak);
    n_assert++;
    if (pin_oe8 !== 8'hFF) begin
      n_fail++; $display("FAIL w8_pin_oe: got %h want ff", pin_oe8);
    end
    access(1'b1, 11'h003, '0, rd, ak);
    n_assert++;
    if (rdata8 !== 32'h0) begin
      n_fail++; $display("FAIL w8_read_out_hi: got %h want 0", rdata8);
    end
    access(1'b1, 11'h004, '0, rd, ak);
    n_assert++;
    if (rdata8 !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL w8_read_oe_lo: got %h want 000000ff", rdata8);
    end
    access(1'b1, 11'h005, '0, rd, ak);
    n_assert++;
    if (rdata8 !== 32'h0) begin
      n_fail++; $display("FAIL w8_read_oe_hi: got %h want 0", rdata8);
    end
  endtask

  task automatic test_interrupt();
    logic [31:0] rd; logic ak;
    access(1'b0, 11'h008, 32'h0000_0020, rd, ak);
    access(1'b0, 11'h00A, 32'h0000_0020, rd, ak);
    pin_in = 64'h20;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL int_early_irq: got %b want 0", irq);
    end
    access(1'b1, 11'h006, '0, rd, ak);
    n_assert++;
    if (rd[5] !== 1'b1 || irq !== 1'b1) begin
      n_fail++; $display("FAIL int_rise: got pinstate5=%b irq=%b want 1 1", rd[5], irq);
    end
    access(1'b1, 11'h00C, '0, rd, ak);
    n_assert++;
    if (rd !== 32'h20) begin
      n_fail++; $display("FAIL int_status: got %h want 20", rd);
    end
    pin_in = '0;
    repeat (4) @(negedge clk);
    access(1'b1, 11'h00C, '0, rd, ak);
    n_assert++;
    if (rd !== 32'h20) begin
      n_fail++; $display("FAIL int_fall_ignored: got %h want 20", rd);
    end
    access(1'b0, 11'h00C, 32'h20, rd, ak);
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL int_w1c_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] rd; logic ak;
    pin_in = 64'h20;
    repeat (3) @(negedge clk);
    pin_in = '0;
    repeat (3) @(negedge clk);
    pin_in = 64'h20;
    @(negedge clk);
    @(negedge clk);
    access(1'b0, 11'h00C, 32'h20, rd, ak);
    n_assert++;
    if (irq !== 1'b1) begin
      n_fail++; $display("FAIL collide_irq: got %b want 1", irq);
    end
    access(1'b1, 11'h00C, '0, rd, ak);
    n_assert++;
    if (rd !== 32'h20) begin
      n_fail++; $display("FAIL collide_status: got %h want 20", rd);
    end
    access(1'b0, 11'h00C, 32'h20, rd, ak);
    pin_in = '0;
    repeat (4) @(negedge clk);
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++; $display("FAIL collide_cleanup_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic ak;
    logic [10:0] seq [3];
    seq[0] = 11'h000; seq[1] = 11'h001; seq[2] = 11'h002;
    for (int i = 0; i < 3; i++) begin
      access(1'b1, seq[i], '0, rd, ak);
      n_assert++;
      if (ak !== 1'b1 || rd !== m_rdata) begin
        n_fail++; $display("FAIL b2b_%0d: got ack=%b rdata=%h want 1 %h", i, ak, rd, m_rdata);
      end
    end
    @(negedge clk);
    n_assert++;
    if (ack !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_idle: got ack=%b rdata=%h want 0 0", ack, rdata);
    end
  endtask

  task automatic test_both_edge();
    logic [31:0] rd; logic ak;
`ifdef GPIO_BOTH_EDGE_EN
    access(1'b0, 11'h012, 32'h08, rd, ak);
    access(1'b0, 11'h008, 32'h08, rd, ak);
    access(1'b0, 11'h00A, 32'h00, rd, ak);
    pin_in = 64'h08;
    repeat (3) @(negedge clk);
    access(1'b1, 11'h00C, '0, rd, ak);
    n_assert++;
    if (rd !== 32'h08 || irq !== 1'b1) begin
      n_fail++; $display("FAIL any_rise: got status=%h irq=%b want 08 1", rd, irq);
    end
    access(1'b0, 11'h00C, 32'h08, rd, ak);
    pin_in = '0;
    repeat (3) @(negedge clk);
    access(1'b1, 11'h00C, '0, rd, ak);
    n_assert++;
    if (rd !== 32'h08 || irq !== 1'b1) begin
      n_fail++; $display("FAIL any_fall: got status=%h irq=%b want 08 1", rd, irq);
    end
    access(1'b0, 11'h00C, 32'h08, rd, ak);
`else
    access(1'b0, 11'h012, 32'hFFFF_FFFF, rd, ak);
    access(1'b1, 11'h012, '0, rd, ak);
    n_assert++;
    if (ak !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL any_unmapped: got ack=%b rdata=%h want 1 0", ak, rd);
    end
`endif
  endtask

  task automatic test_reset_in_flight();
    logic [31:0] rd; logic ak;
    access(1'b0, 11'h002, 32'h0000_1234, rd, ak);
    access(1'b0, 11'h004, 32'h0000_00FF, rd, ak);
    access(1'b0, 11'h008, 32'h0000_0001, rd, ak);
    req = 1'b1; r_wn = 1'b1; addr = 11'h000; rst_n = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({ack, rdata, pin_out, pin_oe, irq} !== '0) begin
      n_fail++; $display("FAIL rif_outputs: got ack=%b rdata=%h out=%h oe=%h irq=%b want all 0",
                         ack, rdata, pin_out, pin_oe, irq);
    end
    req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    access(1'b1, 11'h008, '0, rd, ak);
    n_assert++;
    if (ak !== 1'b1 || rd !== 32'h0) begin
      n_fail++; $display("FAIL rif_int_en: got ack=%b rdata=%h want 1 0", ak, rd);
    end
  endtask

  task automatic test_random();
    logic        was_read;
    logic [10:0] a;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) pin_in = {$urandom, $urandom};
      req  = ($urandom_range(0, 3) != 0);
      r_wn = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 7))
        0:       a = 11'h014 + 11'($urandom_range(0, 20));
        1:       a = 11'($urandom);
        default: a = 11'($urandom_range(0, 19));
      endcase
      addr = a; wdata = $urandom;
      was_read = req && r_wn;
      @(negedge clk);
      n_assert++;
      if (ack !== m_ack || pin_out !== m_out || pin_oe !== m_oe || irq !== m_irq) begin
        n_fail++; $display("FAIL rand_%0d_state: got ack=%b out=%h oe=%h irq=%b want %b %h %h %b",
                           i, ack, pin_out, pin_oe, irq, m_ack, m_out, m_oe, m_irq);
      end
      if (was_read || !m_ack) begin
        n_assert++;
        if (rdata !== m_rdata) begin
          n_fail++; $display("FAIL rand_%0d_rdata addr=%h: got %h want %h", i, a, rdata, m_rdata);
        end
      end
    end
    req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_output();
    test_pin_w8();
    test_interrupt();
    test_w1c_collision();
    test_back_to_back();
    test_both_edge();
    test_reset_in_flight();
    test_random();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_regfile_p.md
Name: gpio_regfile_p

Overview:
- Parametrised GPIO/ID register bank for the RISC-V microcontroller. It is the successor to the fixed 64-bit register skeleton.
- Adds a real bus handshake, pin-count generalisation, set/clear aliases, an input synchroniser and edge-detect interrupts with W1C status.
- Sits between the core's peripheral bus and the pad ring: one 32-bit word per address, 64-bit-capable registers split into LO/HI words.

Parameters:
- PIN_W, 64, number of GPIO pins (1..64); bits at or above PIN_W read 0, writes ignored.
- ADDR_W, 11, word-address width.
- CHIP_NAME, 32'h5256_4943, value returned by CNAME.
- CHIP_VERSION, 32'h0000_0002, value returned by CVERSION.

Ports:
- clk  in  1  master clock
- rst_n  in  1  reset, synchronous, active-low; sampled on posedge clk
- req  in  1  bus access request, one access per cycle it is high
- r_wn  in  1  1 = read, 0 = write (qualified by req)
- addr  in  ADDR_W  word address
- wdata  in  32  write data
- rdata  out  32  read data, valid only while ack=1
- ack  out  1  access complete
- pin_in  in  PIN_W  asynchronous pad inputs
- pin_out  out  PIN_W  output data register
- pin_oe  out  PIN_W  output enable (1 = drive)
- irq  out  1  interrupt request

Behaviour:
- Reset (rst_n=0 at posedge): pin_out=0, pin_oe=0, INT_EN=0, INT_POL=0, INT_STATUS=0, sync/prev flops=0, ack=0, rdata=0, irq=0. An access in flight is dropped and no ack is issued.
- Handshake: req sampled at posedge k.
  - Write side-effects take effect at edge k.
  - ack=1 and rdata are valid after edge k, for one cycle.
  - Back-to-back req cycles give back-to-back acks.
  - When ack=0, rdata=0.
  - Every access is acked, including unmapped addresses.
- Word map (LO = bits 31:0, HI = bits 63:32):
  - 0x000 CNAME RO
  - 0x001 CVERSION RO
  - 0x002/003 OUTPUT RW
  - 0x004/005 TRISTATE RW (drives pin_oe)
  - 0x006/007 PINSTATE RO (synchronised input)
  - 0x008/009 INT_EN RW
  - 0x00A/00B INT_POL RW (1 = rising, 0 = falling)
  - 0x00C/00D INT_STATUS W1C
  - 0x00E/00F OUT_SET: write 1s OR into pin_out; reads return OUTPUT
  - 0x010/011 OUT_CLR: write 1s clear pin_out; reads return OUTPUT
- Unmapped addresses read 0; writes to them and to RO words are ignored.
- HI words with PIN_W <= 32 read 0.
- Input path: 2-flop synchroniser (s1, s2), then prev flop.
  - rise = s2 & ~prev; fall = ~s2 & prev.
  - A pin change set up before edge k appears in PINSTATE after edge k+1.
  - The edge event is computed combinationally from s2 and prev in the cycle after edge k+1, and INT_STATUS sets at edge k+2.
  - Edge match per bit: INT_EN & (INT_POL ? rise : fall).
- INT_STATUS: set on edge match. W1C clears bits written 1. If a new event and W1C hit the same bit in the same cycle, set wins.
- irq = OR of INT_STATUS bits, driven from registered state (no extra latency); it drops the cycle after the last bit is cleared.
- Disabling INT_EN does not clear pending status.
- Pulses shorter than one clock may be missed; there is no stretching.

Optional Feature:
- Macro GPIO_BOTH_EDGE_EN.
- Defined: adds INT_ANY RW at 0x012/013, reset 0. A bit set in INT_ANY triggers on rise|fall regardless of INT_POL (still gated by INT_EN).
- Undefined: 0x012/013 are unmapped (read 0, writes ignored) and no extra flops are built.

Test Plan:
- Reset then read 0x000, 0x001 -> ack one cycle after req, rdata=CHIP_NAME and CHIP_VERSION; all outputs 0 during and after reset.
- Write 0x002=0xA5A5_0000, then OUT_SET 0x00E=0x0000_00FF, then OUT_CLR 0x010=0x0000_000F -> pin_out[31:0] = 0xA5A5_0000, then 0xA5A5_00FF, then 0xA5A5_00F0; read 0x010 returns 0xA5A5_00F0.
- PIN_W=8: write 0x003=0xFFFF_FFFF and 0x004=0xFFFF_FFFF -> read 0x003=0, read 0x004=0x0000_00FF, pin_oe=8'hFF.
- INT_EN[5]=1, INT_POL[5]=1; raise pin_in[5] before edge k -> PINSTATE bit 5 reads 1 on an access sampled at edge k+2 or later; INT_STATUS[5]=1 and irq=1 after edge k+2. A falling edge leaves status unchanged. W1C 0x00C=0x20 -> irq=0 the next cycle.
- W1C of bit 5 in the same cycle a new rising event on pin 5 is detected -> INT_STATUS[5] stays 1 and irq stays 1.
- Assert rst_n=0 in the cycle a read req is sampled -> no ack; all registers return to reset values. With GPIO_BOTH_EDGE_EN defined and INT_ANY[3]=1, INT_EN[3]=1: both rise and fall on pin 3 set status; without the macro, 0x012 reads 0.
